d_branch_resolver: RTL and testbench

//  D-stage branch resolver, successor of the fixed 3-op comparator. Resolves a wider branch-op set
//  on forwarded RS/RT data. Drives taken, likely-branch nullify and mispredict. Owns a PHT_DEPTH-entry
//  2-bit-counter pattern history table: read in F for prediction, trained in D on resolution.

---
 rtl/d_branch_resolver_pkg.sv | 37 +++
 rtl/d_branch_resolver_branch_pht.sv | 47 ++++
 rtl/d_branch_resolver.sv | 113 +++++++++++
 tb/tb_d_branch_resolver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/d_branch_resolver_pkg.sv
// Shared definitions for the D-stage branch resolver.
//   CMP_*       : branch compare op codes carried on cmp_op
//   pht_state_t : 2-bit saturating predictor counter states
//   pht_next()  : counter training step (saturates at both ends)
package d_branch_resolver_pkg;

    localparam int CMP_NONE   = 0;
    localparam int CMP_BEQ    = 1;
    localparam int CMP_BNE    = 2;
    localparam int CMP_BLEZ   = 3;
    localparam int CMP_BGTZ   = 4;
    localparam int CMP_BLTZ   = 5;
    localparam int CMP_BGEZ   = 6;
    localparam int CMP_BLTZAL = 7;
    localparam int CMP_BONALL = 8;

    typedef enum logic [1:0] {
        PHT_SNT = 2'b00,
        PHT_WNT = 2'b01,
        PHT_WT  = 2'b10,
        PHT_ST  = 2'b11
    } pht_state_t;

    function automatic pht_state_t pht_next(input pht_state_t cur, input logic taken);
        pht_state_t nxt;
        nxt = cur;
        case (cur)
            PHT_SNT: nxt = taken ? PHT_WNT : PHT_SNT;
            PHT_WNT: nxt = taken ? PHT_WT  : PHT_SNT;
            PHT_WT:  nxt = taken ? PHT_ST  : PHT_WNT;
            PHT_ST:  nxt = taken ? PHT_ST  : PHT_WT;
            default: nxt = PHT_WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/d_branch_resolver_branch_pht.sv
// Pattern history table of 2-bit saturating counters.
//   clk, reset : clock and synchronous active-high reset (all entries -> WNT)
//   rd_idx     : F-stage lookup index
//   rd_taken   : MSB of the addressed counter (combinational, pre-update value)
//   wr_en      : train the counter at wr_idx this cycle
//   wr_idx     : D-stage training index
//   wr_taken   : resolved direction used to train
module branch_pht
    import d_branch_resolver_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IDX-1:0] rd_idx,
    output logic           rd_taken,
    input  logic           wr_en,
    input  logic [IDX-1:0] wr_idx,
    input  logic           wr_taken
);

    pht_state_t entry_state [DEPTH];

    // Every counter is its own register so that reset clears the whole
    // table in a single cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            pht_state_t entry_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_reg <= PHT_WNT;
                end else if (wr_en && (wr_idx == IDX'(gi))) begin
                    entry_reg <= pht_next(entry_reg, wr_taken);
                end
            end

            assign entry_state[gi] = entry_reg;
        end
    endgenerate

    // Reads see the registered state, so a same-cycle write to the same
    // index only becomes visible on the following cycle.
    assign rd_taken = entry_state[rd_idx][1];

endmodule

// File: rtl/d_branch_resolver.sv
// D-stage branch resolver.
//   clk, reset     : clock, synchronous active-high reset
//   f_pc           : F-stage PC, PHT lookup index f_pc[IDX+1:2]
//   f_pred_taken   : predicted direction for the F-stage instruction
//   d_valid        : D-stage holds a real instruction
//   d_stall        : D-stage held; suppresses training and statistics
//   d_pc           : D-stage PC, PHT training index d_pc[IDX+1:2]
//   d_pred_taken   : prediction carried with the D-stage instruction
//   rs_data/rt_data: forwarded operands
//   cmp_op         : branch compare op (CMP_* codes)
//   b_jump         : branch taken
//   flush_check    : BONALL not taken, nullify delay slot
//   mispredict     : resolved direction differs from d_pred_taken
//   stat_branches  : resolved branch count (wraps)
//   stat_mispred   : mispredict count (wraps)
module d_branch_resolver
    import d_branch_resolver_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PHT_DEPTH = 16,
    parameter int OP_BITS   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        f_pc,
    output logic               f_pred_taken,
    input  logic               d_valid,
    input  logic               d_stall,
    input  logic [31:0]        d_pc,
    input  logic               d_pred_taken,
    input  logic [WIDTH-1:0]   rs_data,
    input  logic [WIDTH-1:0]   rt_data,
    input  logic [OP_BITS-1:0] cmp_op,
    output logic               b_jump,
    output logic               flush_check,
    output logic               mispredict,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispred
);

    localparam int IDX = $clog2(PHT_DEPTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] rs_signed;
    logic [WIDTH-1:0]        bonall_sum;
    logic                    cond;
    logic                    is_op;
    logic                    is_br;
    logic                    update;
    logic [31:0]             stat_branches_reg;
    logic [31:0]             stat_mispred_reg;

    assign rs_signed  = rs_data;
    assign bonall_sum = rs_data + rt_data;

    always_comb begin
        cond  = 1'b0;
        is_op = 1'b1;
        case (cmp_op)
            OP_BITS'(CMP_BEQ):    cond = (rs_data == rt_data);
            OP_BITS'(CMP_BNE):    cond = (rs_data != rt_data);
            OP_BITS'(CMP_BLEZ):   cond = (rs_signed <= 0);
            OP_BITS'(CMP_BGTZ):   cond = (rs_signed > 0);
            OP_BITS'(CMP_BLTZ):   cond = (rs_signed < 0);
            OP_BITS'(CMP_BGEZ):   cond = (rs_signed >= 0);
            OP_BITS'(CMP_BLTZAL): cond = (rs_signed < 0);
            // Two most-negative values also sum to zero mod 2^WIDTH but must
            // not take the branch.
            OP_BITS'(CMP_BONALL): cond = (bonall_sum == '0) &&
                                         !((rs_data == MIN_NEG) && (rt_data == MIN_NEG));
            default:              is_op = 1'b0;
        endcase
    end

    assign is_br       = d_valid && is_op;
    assign b_jump      = is_br && cond;
    assign flush_check = d_valid && (cmp_op == OP_BITS'(CMP_BONALL)) && !b_jump;
    assign mispredict  = is_br && (b_jump != d_pred_taken);
    assign update      = is_br && !d_stall && !reset;

    branch_pht #(
        .DEPTH (PHT_DEPTH),
        .IDX   (IDX)
    ) u_pht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (f_pc[IDX+1:2]),
        .rd_taken (f_pred_taken),
        .wr_en    (update),
        .wr_idx   (d_pc[IDX+1:2]),
        .wr_taken (b_jump)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_reg <= '0;
            stat_mispred_reg  <= '0;
        end else if (update) begin
            stat_branches_reg <= stat_branches_reg + 32'd1;
            if (mispredict) begin
                stat_mispred_reg <= stat_mispred_reg + 32'd1;
            end
        end
    end

    assign stat_branches = stat_branches_reg;
    assign stat_mispred  = stat_mispred_reg;

    // PC bits outside the PHT index carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{f_pc[31:IDX+2], f_pc[1:0], d_pc[31:IDX+2], d_pc[1:0]};

endmodule

// File: tb/tb_d_branch_resolver.sv
module tb_d_branch_resolver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic        d_valid;
    logic        d_stall;
    logic [31:0] d_pc;
    logic        d_pred_taken;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [3:0]  cmp_op;
    logic        b_jump;
    logic        flush_check;
    logic        mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_br = 0;
    logic [31:0] exp_mp = 0;

    always #5 clk = ~clk;

    d_branch_resolver #(
        .WIDTH     (32),
        .PHT_DEPTH (16),
        .OP_BITS   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .f_pc          (f_pc),
        .f_pred_taken  (f_pred_taken),
        .d_valid       (d_valid),
        .d_stall       (d_stall),
        .d_pc          (d_pc),
        .d_pred_taken  (d_pred_taken),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .cmp_op        (cmp_op),
        .b_jump        (b_jump),
        .flush_check   (flush_check),
        .mispredict    (mispredict),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    // Reference direction for the single-operand signed compares.
    function automatic logic ref_cond(input int op, input logic [31:0] rs);
        int s;
        s = int'(rs);
        case (op)
            3:       return s <= 0;
            4:       return s > 0;
            5, 7:    return s < 0;
            6:       return s >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One D-stage transaction: drive, push expected {b_jump,flush,mispredict},
    // compare in the low phase of the same cycle.
    task automatic step(input string tag, input int op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] pc,
                        input logic pred, input logic stall,
                        input logic exp_bj, input logic exp_fc);
        logic isbr;
        logic emp;
        @(posedge clk);
        #1;
        cmp_op       = op[3:0];
        rs_data      = rs;
        rt_data      = rt;
        d_pc         = pc;
        d_pred_taken = pred;
        d_stall      = stall;
        d_valid      = 1'b1;
        isbr = (op >= 1) && (op <= 8);
        emp  = isbr && (exp_bj != pred);
        exp_q.push_back({29'd0, exp_bj, exp_fc, emp});
        if (isbr && !stall) begin
            exp_br++;
            if (emp) exp_mp++;
        end
        $display("step %s op=%0d rs=%h rt=%h pc=%h pred=%0d stall=%0d", tag, op, rs, rt, pc, pred, stall);
        @(negedge clk);
        compare(tag, {29'd0, b_jump, flush_check, mispredict});
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
        f_pc = pc;
        #1;
        exp_q.push_back({31'd0, exp});
        compare(tag, {31'd0, f_pred_taken});
    endtask

    task automatic check_stats(input string tag);
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        d_stall = 1'b0;
        cmp_op  = 4'd0;
        @(negedge clk);
        $display("stats %s branches=%0d mispred=%0d", tag, stat_branches, stat_mispred);
        exp_q.push_back(exp_br);
        compare({tag, "_branches"}, stat_branches);
        exp_q.push_back(exp_mp);
        compare({tag, "_mispred"}, stat_mispred);
    endtask

    initial begin
        reset        = 1'b1;
        f_pc         = 32'h0;
        d_valid      = 1'b0;
        d_stall      = 1'b0;
        d_pc         = 32'h0;
        d_pred_taken = 1'b0;
        rs_data      = 32'h0;
        rt_data      = 32'h0;
        cmp_op       = 4'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(32'd0);
        compare("reset_outs", {29'd0, b_jump, flush_check, mispredict});
        check_pred("reset_pred", 32'h0, 1'b0);
        exp_q.push_back(32'd0);
        compare("reset_branches", stat_branches);
        exp_q.push_back(32'd0);
        compare("reset_mispred", stat_mispred);
        reset = 1'b0;

        // 1: BEQ taken while predicted not-taken
        step("beq_eq", 1, 32'd5, 32'd5, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check_stats("after_beq");

        // 2: BONALL and other op codes
        step("bonall_zero", 8, 32'd3, 32'hFFFF_FFFD, 32'h08, 1'b1, 1'b0, 1'b1, 1'b0);
        step("bonall_minneg", 8, 32'h8000_0000, 32'h8000_0000, 32'h08, 1'b0, 1'b0, 1'b0, 1'b1);
        step("bonall_nonzero", 8, 32'd1, 32'hFFFF_FFFE, 32'h0C, 1'b1, 1'b0, 1'b0, 1'b1);
        step("bne_diff", 2, 32'd7, 32'd9, 32'h0C, 1'b1, 1'b0, 1'b1, 1'b0);
        step("beq_diff", 1, 32'd7, 32'd9, 32'h0C, 1'b1, 1'b0, 1'b0, 1'b0);
        step("none", 0, 32'd0, 32'd0, 32'h0C, 1'b1, 1'b0, 1'b0, 1'b0);
        step("op9", 9, 32'd0, 32'd0, 32'h0C, 1'b1, 1'b0, 1'b0, 1'b0);
        step("op15", 15, 32'd5, 32'd5, 32'h0C, 1'b0, 1'b0, 1'b0, 1'b0);
        step("bltzal_neg", 7, 32'hFFFF_FFF0, 32'd0, 32'h0C, 1'b0, 1'b0, 1'b1, 1'b0);

        // 3: signed single-operand sweep
        begin
            int ops [4];
            logic [31:0] vals [3];
            ops  = '{3, 4, 6, 5};
            vals = '{32'd0, 32'd1, 32'hFFFF_FFFF};
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 3; j++) begin
                    step($sformatf("sweep_op%0d_rs%h", ops[i], vals[j]), ops[i], vals[j],
                         32'h1234_5678, 32'h10, 1'b0, 1'b0, ref_cond(ops[i], vals[j]), 1'b0);
                end
            end
        end
        check_stats("after_sweep");

        // 4: counter training and saturation on one index, read in same cycle
        check_pred("pht5_init", 32'h14, 1'b0);
        step("t1", 1, 32'd1, 32'd1, 32'h14, 1'b0, 1'b0, 1'b1, 1'b0);
        check_pred("pht5_t1_same_cycle", 32'h14, 1'b0);
        step("t2", 1, 32'd1, 32'd1, 32'h14, 1'b1, 1'b0, 1'b1, 1'b0);
        check_pred("pht5_after_t1", 32'h14, 1'b1);
        step("t3", 1, 32'd1, 32'd1, 32'h14, 1'b1, 1'b0, 1'b1, 1'b0);
        check_pred("pht5_after_t2", 32'h14, 1'b1);
        step("t4", 1, 32'd1, 32'd1, 32'h14, 1'b1, 1'b0, 1'b1, 1'b0);
        check_pred("pht5_after_t3", 32'h14, 1'b1);
        step("n1", 2, 32'd1, 32'd1, 32'h14, 1'b1, 1'b0, 1'b0, 1'b0);
        check_pred("pht5_sat_st", 32'h14, 1'b1);
        step("n2", 2, 32'd1, 32'd1, 32'h14, 1'b1, 1'b0, 1'b0, 1'b0);
        check_pred("pht5_after_n1", 32'h14, 1'b1);
        step("n3", 2, 32'd1, 32'd1, 32'h14, 1'b0, 1'b0, 1'b0, 1'b0);
        check_pred("pht5_after_n2", 32'h14, 1'b0);
        step("n4", 2, 32'd1, 32'd1, 32'h14, 1'b0, 1'b0, 1'b0, 1'b0);
        check_pred("pht5_after_n3", 32'h14, 1'b0);
        step("n5", 2, 32'd1, 32'd1, 32'h14, 1'b0, 1'b0, 1'b0, 1'b0);
        check_pred("pht5_after_n4", 32'h14, 1'b0);
        step("t5", 1, 32'd1, 32'd1, 32'h14, 1'b0, 1'b0, 1'b1, 1'b0);
        check_pred("pht5_sat_snt", 32'h14, 1'b0);
        check_stats("after_train");
        check_pred("pht5_after_t5", 32'h14, 1'b0);
        check_pred("pht4_untouched_by_5", 32'h10, 1'b0);

        // 5: stalled branch resolves but does not train or count
        step("stall_beq", 1, 32'd2, 32'd2, 32'h18, 1'b0, 1'b1, 1'b1, 1'b0);
        check_stats("after_stall");
        check_pred("pht6_after_stall", 32'h18, 1'b0);

        // 6: reset during a taken branch
        step("pre_rst1", 1, 32'd3, 32'd3, 32'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
        step("pre_rst2", 1, 32'd3, 32'd3, 32'h1C, 1'b1, 1'b0, 1'b1, 1'b0);
        check_pred("pht7_before_reset", 32'h1C, 1'b1);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        cmp_op       = 4'd1;
        rs_data      = 32'd4;
        rt_data      = 32'd4;
        d_pc         = 32'h1C;
        d_pred_taken = 1'b0;
        d_valid      = 1'b1;
        d_stall      = 1'b0;
        $display("step reset_beq op=1 rs=4 rt=4 pc=1c reset=1");
        @(negedge clk);
        exp_q.push_back({29'd0, 1'b1, 1'b0, 1'b1});
        compare("reset_beq_outs", {29'd0, b_jump, flush_check, mispredict});
        @(posedge clk);
        #1;
        reset   = 1'b0;
        d_valid = 1'b0;
        cmp_op  = 4'd0;
        exp_br  = 32'd0;
        exp_mp  = 32'd0;
        @(negedge clk);
        exp_q.push_back(exp_br);
        compare("midrst_branches", stat_branches);
        exp_q.push_back(exp_mp);
        compare("midrst_mispred", stat_mispred);
        for (int k = 0; k < 16; k++) begin
            check_pred($sformatf("midrst_pht%0d", k), 32'(k * 4), 1'b0);
        end

        // Training resumes normally after reset
        step("post_rst", 1, 32'd6, 32'd6, 32'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
        check_stats("after_post_rst");
        check_pred("pht7_post_rst", 32'h1C, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
